digit_serial_add_seq: RTL and testbench



---
 rtl/digit_serial_add_seq.sv | 127 ++++++++++++
 tb/tb_digit_serial_add_seq.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/digit_serial_add_seq.sv
// Sequential driver for a 3-bit carry-in slice adder: adds two WIDTH-bit operands one digit per cycle, LSB digit first.
// Latency NDIG cycles from acceptance to out_valid; the result is held indefinitely while out_ready is low.
module digit_serial_add_seq #(
   parameter  int WIDTH = 12,
   localparam int NDIG  = WIDTH / 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             op_cin,
   output logic [2:0]       slc_a,
   output logic [2:0]       slc_b,
   output logic             slc_cin,
   input  logic [2:0]       slc_sum,
   input  logic             slc_cout,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [IW-1:0] LAST = IW'(NDIG - 1);

   generate
      if ((WIDTH % 3) != 0 || WIDTH < 3) begin : g_bad_width
         $error("digit_serial_add_seq: WIDTH must be a multiple of 3 and at least 3");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             cout_q, cout_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         res_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         carry_q <= carry_d;
         res_q   <= res_d;
         cout_q  <= cout_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      carry_d = carry_q;
      res_d   = res_q;
      cout_d  = cout_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = op_a;
               b_d     = op_b;
               carry_d = op_cin;
               idx_d   = '0;
               res_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            // Slice results are taken verbatim so an approximate slice shows through unchanged.
            res_d[3*idx_q +: 3] = slc_sum;
            carry_d             = slc_cout;
            if (idx_q == LAST) begin
               cout_d  = slc_cout;
               idx_d   = '0;
               state_d = DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Slice inputs come only from registers, so there is no in-to-out combinational path.
   always_comb begin
      slc_a   = 3'd0;
      slc_b   = 3'd0;
      slc_cin = 1'b0;
      if (state_q == RUN) begin
         slc_a   = a_q[3*idx_q +: 3];
         slc_b   = b_q[3*idx_q +: 3];
         slc_cin = carry_q;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign sum       = res_q;
   assign cout      = cout_q;

endmodule

// File: tb/tb_digit_serial_add_seq.sv
// Directed bench for digit_serial_add_seq with a behavioural slice model that can be switched to a fixed bogus response.
module tb_digit_serial_add_seq;

   localparam int WIDTH = 12;
   localparam int NDIG  = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] op_a = '0;
   logic [WIDTH-1:0] op_b = '0;
   logic             op_cin = 1'b0;
   logic [2:0]       slc_a, slc_b;
   logic             slc_cin;
   logic [2:0]       slc_sum;
   logic             slc_cout;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             bad_slice = 1'b0;

   int nchk = 0;
   int nerr = 0;

   logic [2:0] sa_seq [NDIG];
   logic [2:0] sb_seq [NDIG];
   logic       sc_seq [NDIG];

   digit_serial_add_seq #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .op_a(op_a), .op_b(op_b), .op_cin(op_cin),
      .slc_a(slc_a), .slc_b(slc_b), .slc_cin(slc_cin),
      .slc_sum(slc_sum), .slc_cout(slc_cout),
      .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout)
   );

   always #5 clk = ~clk;

   always_comb begin
      slc_sum  = 3'd0;
      slc_cout = 1'b1;
      if (!bad_slice) begin
         {slc_cout, slc_sum} = {1'b0, slc_a} + {1'b0, slc_b} + {3'b000, slc_cin};
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      if (obs !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_slc_a"}, 32'(slc_a), 32'd0);
      check({tag, "_slc_b"}, 32'(slc_b), 32'd0);
      check({tag, "_slc_cin"}, 32'(slc_cin), 32'd0);
   endtask

   // Presents a request, records the slice inputs over the RUN cycles, and returns at the first DONE cycle.
   task automatic request(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin);
      int guard = 0;
      while (!in_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      check("wait_in_ready", 32'(in_ready), 32'd1);
      op_a = a; op_b = b; op_cin = cin; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      for (int k = 0; k < NDIG; k++) begin
         sa_seq[k] = slc_a;
         sb_seq[k] = slc_b;
         sc_seq[k] = slc_cin;
         check("run_out_valid", 32'(out_valid), 32'd0);
         check("run_in_ready", 32'(in_ready), 32'd0);
         @(negedge clk);
      end
      check("done_out_valid", 32'(out_valid), 32'd1);
      check("done_in_ready", 32'(in_ready), 32'd0);
      check_idle_outputs("done");
   endtask

   task automatic release_result();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("rel_out_valid", 32'(out_valid), 32'd0);
      check("rel_in_ready", 32'(in_ready), 32'd1);
      check_idle_outputs("idle");
   endtask

   initial begin
      #2 rst_n = 1'b0;
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_sum", 32'(sum), 32'd0);
      check("rst_cout", 32'(cout), 32'd0);
      check_idle_outputs("rst");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // 0x123 + 0x456 + 1 = 0x57A
      request(12'h123, 12'h456, 1'b1);
      check("add1_sum", 32'(sum), 32'h57A);
      check("add1_cout", 32'(cout), 32'd0);
      release_result();

      // Carry ripples through every digit
      request(12'hFFF, 12'h001, 1'b0);
      check("ovf_sum", 32'(sum), 32'h000);
      check("ovf_cout", 32'(cout), 32'd1);
      check("ovf_cin0", 32'(sc_seq[0]), 32'd0);
      check("ovf_cin1", 32'(sc_seq[1]), 32'd1);
      check("ovf_cin2", 32'(sc_seq[2]), 32'd1);
      check("ovf_cin3", 32'(sc_seq[3]), 32'd1);
      release_result();

      // Digit order: 0x123 = octal 0443
      request(12'h123, 12'h000, 1'b0);
      check("ord_a0", 32'(sa_seq[0]), 32'd3);
      check("ord_a1", 32'(sa_seq[1]), 32'd4);
      check("ord_a2", 32'(sa_seq[2]), 32'd4);
      check("ord_a3", 32'(sa_seq[3]), 32'd0);
      check("ord_b1", 32'(sb_seq[1]), 32'd0);
      check("ord_sum", 32'(sum), 32'h123);
      release_result();

      // Backpressure with stray in_valid pulses in RUN and DONE
      fork
         begin
            @(posedge clk);
            @(negedge clk);
            @(negedge clk);
            in_valid = 1'b1;
            op_a = 12'h7FF;
            @(negedge clk);
            in_valid = 1'b0;
         end
         request(12'h0A5, 12'h15A, 1'b0);
      join
      for (int k = 0; k < 5; k++) begin
         if (k == 2) in_valid = 1'b1;
         if (k == 3) in_valid = 1'b0;
         check("bp_out_valid", 32'(out_valid), 32'd1);
         check("bp_sum", 32'(sum), 32'h1FF);
         check("bp_cout", 32'(cout), 32'd0);
         @(negedge clk);
      end
      release_result();
      for (int k = 0; k < 8; k++) begin
         check("bp_no_extra", 32'(out_valid), 32'd0);
         @(negedge clk);
      end

      // Reset abort at idx=2
      op_a = 12'h123; op_b = 12'h456; op_cin = 1'b1; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("abort_pre_slc_a", 32'(slc_a), 32'd4);
      #2 rst_n = 1'b0;
      #1;
      check("abort_in_ready", 32'(in_ready), 32'd1);
      check("abort_out_valid", 32'(out_valid), 32'd0);
      check("abort_sum", 32'(sum), 32'd0);
      check("abort_cout", 32'(cout), 32'd0);
      check_idle_outputs("abort");
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         check("abort_no_result", 32'(out_valid), 32'd0);
         @(negedge clk);
      end
      request(12'h007, 12'h001, 1'b0);
      check("post_abort_sum", 32'(sum), 32'h008);
      check("post_abort_cout", 32'(cout), 32'd0);
      release_result();

      // Bogus slice: results must follow the slice, not real arithmetic
      bad_slice = 1'b1;
      request(12'h123, 12'h456, 1'b1);
      check("sub_sum", 32'(sum), 32'h000);
      check("sub_cout", 32'(cout), 32'd1);
      check("sub_cin2", 32'(sc_seq[2]), 32'd1);
      release_result();
      bad_slice = 1'b0;

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: simulation did not complete, errors=%0d checks=%0d", nerr, nchk);
      $fatal(1);
   end

endmodule
